// File: rtl/gpio_weight_loader_pkg.sv
// rtl/gpio_weight_loader_pkg.sv - shared state type and checksum helper for the GPIO weight loader
package gpio_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } loader_state_e;

  // Payload sum plus checksum word must wrap to zero in the low width bits.
  // Operands are zero-extended to 64 bits so one function serves any DATA_W <= 64.
  function automatic logic checksum_ok(input logic [63:0] sum,
                                       input logic [63:0] chk,
                                       input int          width);
    logic [63:0] mask;
    logic [63:0] total;
    mask  = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    total = sum + chk;
    return ((total & mask) == 64'd0);
  endfunction

endpackage

// File: rtl/gpio_weight_loader_if.sv
// rtl/gpio_weight_loader_if.sv - Pi-side bus and compute-core read port of the weight loader
interface gpio_weight_loader_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LED_W  = 6
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] gpio_pin;
  logic              write_enable;
  logic              frame_start;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [AW-1:0]     led_sel;
  logic [LED_W-1:0]  LED;
  logic [CW-1:0]     count;
  logic              weights_valid;
  logic              busy;
  logic              crc_err;
  logic              overflow;

  modport master (
    output gpio_pin, write_enable, frame_start, rd_addr, led_sel,
    input  rd_data, LED, count, weights_valid, busy, crc_err, overflow
  );

  modport slave (
    input  gpio_pin, write_enable, frame_start, rd_addr, led_sel,
    output rd_data, LED, count, weights_valid, busy, crc_err, overflow
  );

endinterface

// File: rtl/gpio_weight_loader_bank_pair.sv
// rtl/gpio_weight_loader_bank_pair.sv - double-buffered weight memory with registered read and LED tap
module weight_bank_pair #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LED_W  = 6,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic [AW-1:0]     led_sel,
  output logic [LED_W-1:0]  led
);

  localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];
  logic              bank_sel;   // 0: bank0 is active, bank1 is shadow
  logic              rd_hit;
  logic              led_hit;
  logic [DATA_W-1:0] active_rd;

  // Addresses past DEPTH (only possible when DEPTH is not a power of two) read as zero.
  assign rd_hit  = ({1'b0, rd_addr} < DEPTH_LIM);
  assign led_hit = ({1'b0, led_sel} < DEPTH_LIM);

  // Select the active-bank word feeding the read register.
  always_comb begin
    active_rd = '0;
    if (rd_hit) active_rd = bank_sel ? bank1[rd_addr] : bank0[rd_addr];
  end

  // LED mirrors the low bits of the selected active word without a register.
  always_comb begin
    led = '0;
    if (led_hit) led = bank_sel ? bank1[led_sel][LED_W-1:0] : bank0[led_sel][LED_W-1:0];
  end

  // Payload words land only in the shadow bank; swap flips which bank the core sees.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
      bank_sel <= 1'b0;
    end else begin
      if (wr_en) begin
        if (bank_sel) bank0[wr_addr] <= wr_data;
        else          bank1[wr_addr] <= wr_data;
      end
      if (swap) bank_sel <= ~bank_sel;
    end
  end

  // Read register samples the pre-swap bank on the swap edge, the new one afterwards.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) rd_data <= '0;
    else       rd_data <= active_rd;
  end

endmodule

// File: rtl/gpio_weight_loader.sv
// rtl/gpio_weight_loader.sv - framed GPIO weight capture with checksum-gated bank swap
module gpio_weight_loader
  import gpio_loader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LED_W  = 6
) (
  input  logic                 pi_clk,
  input  logic                 rst_n,
  gpio_weight_loader_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  loader_state_e     state, state_next;
  logic [CW-1:0]     word_count, count_next;
  logic [DATA_W-1:0] sum, sum_next;
  logic              valid, valid_next;
  logic              crc_flag, crc_next;
  logic              ovf_flag, ovf_next;
  logic              wr_en;
  logic              swap;
  logic              chk_pass;

  assign chk_pass = checksum_ok(64'(sum), 64'(bus.gpio_pin), DATA_W);

  // Next-state and datapath decisions; frame_start overrides any same-cycle word.
  always_comb begin
    state_next = state;
    count_next = word_count;
    sum_next   = sum;
    valid_next = valid;
    crc_next   = crc_flag;
    ovf_next   = ovf_flag;
    wr_en      = 1'b0;
    swap       = 1'b0;
    if (bus.frame_start) begin
      state_next = LOAD;
      count_next = '0;
      sum_next   = '0;
      crc_next   = 1'b0;
    end else if (bus.write_enable) begin
      unique case (state)
        LOAD: begin
          wr_en      = 1'b1;
          sum_next   = sum + bus.gpio_pin;
          count_next = word_count + CW'(1);
          if (word_count == LAST_IDX) state_next = CHECK;
        end
        CHECK: begin
          if (chk_pass) begin
            swap       = 1'b1;
            valid_next = 1'b1;
            state_next = DONE;
          end else begin
            crc_next   = 1'b1;
            state_next = ERROR;
          end
        end
        default: ovf_next = 1'b1;
      endcase
    end
  end

  // State, counters and sticky flags; reset discards any partial frame.
  always_ff @(posedge pi_clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      word_count <= '0;
      sum        <= '0;
      valid      <= 1'b0;
      crc_flag   <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      state      <= state_next;
      word_count <= count_next;
      sum        <= sum_next;
      valid      <= valid_next;
      crc_flag   <= crc_next;
      ovf_flag   <= ovf_next;
    end
  end

  assign bus.count         = word_count;
  assign bus.weights_valid = valid;
  assign bus.crc_err       = crc_flag;
  assign bus.overflow      = ovf_flag;
  assign bus.busy          = (state == LOAD) || (state == CHECK);

  weight_bank_pair #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LED_W  (LED_W),
    .AW     (AW)
  ) u_banks (
    .clk     (pi_clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (word_count[AW-1:0]),
    .wr_data (bus.gpio_pin),
    .swap    (swap),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data),
    .led_sel (bus.led_sel),
    .led     (bus.LED)
  );

endmodule

// File: tb/tb_gpio_weight_loader.sv
// tb/tb_gpio_weight_loader.sv - self-checking bench for gpio_weight_loader
module tb_gpio_weight_loader;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LED_W  = 6;

  logic pi_clk = 1'b0;
  logic rst_n  = 1'b1;

  always #5 pi_clk = ~pi_clk;

  gpio_weight_loader_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LED_W(LED_W)) bus ();

  gpio_weight_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LED_W(LED_W)) dut (
    .pi_clk (pi_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [1:0] addr;
    logic [7:0] exp_rd;
    logic [5:0] exp_led;
  } vec_t;

  int         tests = 0;
  int         fails = 0;
  vec_t       vecs [4];
  logic [7:0] model [4];
  logic [7:0] rd_q [$];
  logic [7:0] run_sum;

  task automatic step();
    @(posedge pi_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic build_table();
    for (int i = 0; i < 4; i++) begin
      vecs[i].addr    = 2'(i);
      vecs[i].exp_rd  = model[i];
      vecs[i].exp_led = model[i][5:0];
    end
  endtask

  task automatic run_table(input string tag);
    build_table();
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = vecs[i].addr;
      bus.led_sel = vecs[i].addr;
      rd_q.push_back(vecs[i].exp_rd);
      step();
      check($sformatf("%s_led%0d", tag, i), 32'(bus.LED), 32'(vecs[i].exp_led));
      if (rd_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL %s_rd%0d: scoreboard empty, got 0x%0h", tag, i, bus.rd_data);
      end else begin
        check($sformatf("%s_rd%0d", tag, i), 32'(bus.rd_data), 32'(rd_q.pop_front()));
      end
    end
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    run_sum = 8'h00;
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    bus.write_enable = 1'b1;
    bus.gpio_pin     = w;
    step();
    bus.write_enable = 1'b0;
    run_sum = run_sum + w;
    repeat (gap) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1);
  end

  initial begin
    bus.gpio_pin     = '0;
    bus.write_enable = 1'b0;
    bus.frame_start  = 1'b0;
    bus.rd_addr      = '0;
    bus.led_sel      = '0;
    run_sum          = 8'h00;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;

    rst_n = 1'b1;
    repeat (2) step();
    rst_n = 1'b0;
    step();

    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_valid", 32'(bus.weights_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_crc", 32'(bus.crc_err), 32'd0);
    check("reset_ovf", 32'(bus.overflow), 32'd0);
    run_table("reset");

    // Frame 1: good checksum, watch the swap edge on rd_addr=2.
    start_frame();
    check("f1_busy", 32'(bus.busy), 32'd1);
    check("f1_count0", 32'(bus.count), 32'd0);
    send_word(8'h01, 0);
    send_word(8'h02, 0);
    send_word(8'h03, 0);
    check("f1_count3", 32'(bus.count), 32'd3);
    send_word(8'h04, 0);
    check("f1_count4", 32'(bus.count), 32'd4);
    check("f1_check_busy", 32'(bus.busy), 32'd1);
    bus.rd_addr = 2'd2;
    bus.led_sel = 2'd3;
    send_word(8'hF6, 0);
    check("f1_swap_old_rd", 32'(bus.rd_data), 32'h00);
    check("f1_valid", 32'(bus.weights_valid), 32'd1);
    check("f1_crc", 32'(bus.crc_err), 32'd0);
    check("f1_done_busy", 32'(bus.busy), 32'd0);
    check("f1_led3", 32'(bus.LED), 32'h04);
    step();
    check("f1_swap_new_rd", 32'(bus.rd_data), 32'h03);
    model[0] = 8'h01; model[1] = 8'h02; model[2] = 8'h03; model[3] = 8'h04;
    run_table("f1");

    // Frame 2: bad checksum leaves the active bank alone.
    start_frame();
    send_word(8'h10, 0);
    send_word(8'h20, 0);
    send_word(8'h30, 0);
    send_word(8'h40, 0);
    send_word(8'h00, 0);
    check("f2_crc", 32'(bus.crc_err), 32'd1);
    check("f2_valid", 32'(bus.weights_valid), 32'd1);
    check("f2_busy", 32'(bus.busy), 32'd0);
    check("f2_count", 32'(bus.count), 32'd4);
    check("f2_ovf", 32'(bus.overflow), 32'd0);
    run_table("f2");

    // Frame 3: frame_start collides with a write of 0xAA, then gapped words.
    bus.frame_start  = 1'b1;
    bus.write_enable = 1'b1;
    bus.gpio_pin     = 8'hAA;
    step();
    bus.frame_start  = 1'b0;
    bus.write_enable = 1'b0;
    run_sum = 8'h00;
    check("f3_count0", 32'(bus.count), 32'd0);
    check("f3_busy", 32'(bus.busy), 32'd1);
    check("f3_crc_clr", 32'(bus.crc_err), 32'd0);
    send_word(8'hC5, 3);
    send_word(8'h46, 3);
    check("f3_count2_gap", 32'(bus.count), 32'd2);
    send_word(8'h87, 3);
    send_word(8'hFF, 3);
    send_word(8'h00 - run_sum, 0);
    check("f3_valid", 32'(bus.weights_valid), 32'd1);
    check("f3_crc", 32'(bus.crc_err), 32'd0);
    check("f3_busy_done", 32'(bus.busy), 32'd0);
    model[0] = 8'hC5; model[1] = 8'h46; model[2] = 8'h87; model[3] = 8'hFF;
    run_table("f3");

    // Writes after DONE raise overflow and change nothing else.
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    check("ovf_set", 32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd4);
    run_table("ovf");

    // Bad frame, then frame_start clears crc_err but keeps overflow.
    start_frame();
    send_word(8'h01, 0);
    send_word(8'h01, 0);
    send_word(8'h01, 0);
    send_word(8'h01, 0);
    send_word(8'h00, 0);
    check("f4_crc", 32'(bus.crc_err), 32'd1);
    start_frame();
    check("f5_crc_clr", 32'(bus.crc_err), 32'd0);
    check("f5_ovf_kept", 32'(bus.overflow), 32'd1);
    check("f5_valid_kept", 32'(bus.weights_valid), 32'd1);

    // Asynchronous reset two words into a frame.
    send_word(8'h33, 0);
    send_word(8'h44, 0);
    check("f5_count2", 32'(bus.count), 32'd2);
    bus.led_sel = 2'd0;
    #1;
    check("pre_rst_led", 32'(bus.LED), 32'h05);
    #1;
    rst_n = 1'b1;
    #1;
    check("async_count", 32'(bus.count), 32'd0);
    check("async_valid", 32'(bus.weights_valid), 32'd0);
    check("async_busy", 32'(bus.busy), 32'd0);
    check("async_ovf", 32'(bus.overflow), 32'd0);
    check("async_crc", 32'(bus.crc_err), 32'd0);
    check("async_led", 32'(bus.LED), 32'd0);
    check("async_rd", 32'(bus.rd_data), 32'd0);
    step();
    rst_n = 1'b0;
    step();
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    run_table("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpio_weight_loader.md
Name: gpio_weight_loader

Overview:
Receives a framed stream of weight words from the Raspberry Pi GPIO bus and stores them in a double-buffered memory of DEPTH words. Each frame ends with a checksum word. The bank swap happens only after the checksum passes, so the neural-net datapath never sees a partial or corrupt weight set. This block generalises the existing 4-byte GPIO capture and LED viewer: width and depth are parameters, and it adds framing, checksum, overflow detection and a registered read port for the compute core.

Parameters:
DATA_W, 8, width of gpio_pin, each memory word and the checksum
DEPTH, 16, payload words per frame and words per bank (>=2)
LED_W, 6, LED output width (LED_W <= DATA_W)
AW, $clog2(DEPTH), derived; address width
CW, $clog2(DEPTH+1), derived; count width

Ports:
pi_clk  in  1  Raspberry Pi clock; all logic on its rising edge
rst_n  in  1  asynchronous, active-high reset
gpio_pin  in  DATA_W  data word from the Pi
write_enable  in  1  high = gpio_pin is valid this cycle (one word per cycle)
frame_start  in  1  single-cycle pulse; starts a new frame
rd_addr  in  AW  compute-core read address into the active bank
rd_data  out  DATA_W  registered read data from the active bank
led_sel  in  AW  word of the active bank to show on LED
LED  out  LED_W  active_bank[led_sel][LED_W-1:0], combinational
count  out  CW  payload words accepted in the current frame
weights_valid  out  1  active bank holds a checksum-verified frame
busy  out  1  state is LOAD or CHECK
crc_err  out  1  sticky; last frame failed checksum
overflow  out  1  sticky; write_enable was seen outside LOAD/CHECK

Behaviour:
- Reset, asynchronous, rst_n=1: state=IDLE, both banks cleared to 0, active bank=0, count=0, running sum=0, rd_data=0, weights_valid=0, crc_err=0, overflow=0. LED therefore reads 0.
- A reset asserted mid-frame discards the frame completely. No bank swap occurs.
- States: IDLE, LOAD, CHECK, DONE, ERROR.
- frame_start, from any state: next state is LOAD. count=0, sum=0, crc_err=0. weights_valid and the active bank are unchanged.
- frame_start takes priority over write_enable in the same cycle. That cycle's word is discarded.
- LOAD with write_enable: shadow[count] <= gpio_pin, sum <= sum + gpio_pin (mod 2^DATA_W), count++. On the DEPTH-th word, go to CHECK.
- CHECK with write_enable: gpio_pin is the checksum. The frame passes if gpio_pin == (~sum + 1), i.e. payload plus checksum sums to 0 mod 2^DATA_W.
  - Pass: on the next edge, swap the active/shadow bank select, set weights_valid=1, go to DONE.
  - Fail: set crc_err=1, go to ERROR. No swap; weights_valid is unchanged.
- IDLE, DONE or ERROR with write_enable (and no frame_start): word ignored, overflow <= 1 (sticky until reset).
- frame_start does not clear overflow.
- write_enable low: no state change and no count change. Stalls of any length are allowed.
- rd_data: 1-cycle latency. The value is registered from the active bank at rd_addr.
  - On the swap edge, rd_data still shows the old bank. The cycle after the swap it shows the new bank.
- rd_addr or led_sel >= DEPTH (non-power-of-2 DEPTH): rd_data and LED return 0.
- count saturates at DEPTH while in CHECK/DONE/ERROR and holds until frame_start or reset.
- busy = (state==LOAD || state==CHECK).

Decomposition:
- Package gpio_loader_pkg:
  - loader_state_e enum (IDLE, LOAD, CHECK, DONE, ERROR)
  - checksum_ok function (sum, chk, width generic via DATA_W)
- Sub-module weight_bank_pair:
  - two DEPTH x DATA_W arrays
  - bank select flip-flop
  - write port into the shadow bank
  - registered read port and combinational LED tap on the active bank
  - asynchronous clear
- Top level holds the FSM, count, sum and sticky flags.

Test Plan:
- Reset then idle, rd_addr/led_sel swept 0..DEPTH-1 -> rd_data=0, LED=0, weights_valid=0, count=0.
- DEPTH=4: frame_start, write 0x01,0x02,0x03,0x04, then checksum 0xF6 -> weights_valid=1, crc_err=0. rd_addr=2 gives rd_data=0x03 one cycle later. led_sel=3 gives LED=0x04.
- Second frame 0x10,0x20,0x30,0x40 with a bad checksum 0x00 -> crc_err=1, state ERROR. The active bank still reads 0x01..0x04; weights_valid stays 1.
- Frame with write_enable gaps of 3 cycles between words, plus frame_start coincident with write_enable=1 on data 0xAA -> 0xAA is not stored, count=0 after the pulse, and the frame still passes.
- After DONE, two extra writes -> overflow=1, count stays 4, memory unchanged. A following frame_start clears crc_err but not overflow.
- rst_n asserted after 2 of 4 words of a frame -> everything is 0 immediately (asynchronous, no clock edge needed) and weights_valid=0.
